// File: rtl/byte_data_memory.sv
// rtl/byte_data_memory.sv - byte-addressed big-endian MIPS data memory with fault reporting
// One request per cycle in IDLE; loads respond one cycle after acceptance.
module byte_data_memory #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        write_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  input  logic [31:0] address_in,
  input  logic [31:0] data_in,
  output logic        rdata_valid_out,
  output logic [31:0] data_out,
  output logic        fault_out
);

  localparam int WORDS = (2 ** ADDR_W) / 4;
  localparam int IW    = ADDR_W - 2;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_IDLE  = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] clr_idx;
  logic [31:0]   mem [WORDS];

  logic          accept;
  logic          req_fault;
  logic          do_store;
  logic          clearing;
  logic [IW-1:0] widx;
  logic [1:0]    off;
  logic [1:0]    lane;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   rext;

  assign req_ready_out = (state == S_IDLE);
  assign accept        = rst_n & req_valid_in & req_ready_out;
  assign widx          = address_in[ADDR_W-1:2];
  assign off           = address_in[1:0];
  // Big-endian: byte offset 0 lives in the most significant lane.
  assign lane          = 2'd3 - off;
  assign do_store      = accept & write_in & ~req_fault;
  assign clearing      = CLEAR_ON_RESET && rst_n && (state == S_RESET || state == S_CLEAR);

  always_comb begin
    req_fault = 1'b0;
    case (size_in)
      2'b00:   req_fault = 1'b0;
      2'b01:   req_fault = off[0];
      2'b10:   req_fault = |off;
      default: req_fault = 1'b1;
    endcase
    if (|address_in[31:ADDR_W]) req_fault = 1'b1;
  end

  always_comb begin
    rword = mem[widx];
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = off[1] ? rword[15:0] : rword[31:16];
    case (size_in)
      2'b00:   rext = unsigned_in ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   rext = unsigned_in ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: rext = rword;
    endcase
  end

  // Array has no reset; the clear sweep takes priority over stores (never concurrent anyway).
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_idx] <= 32'h0;
    end else if (do_store) begin
      case (size_in)
        2'b00: mem[widx][{lane, 3'b000} +: 8] <= data_in[7:0];
        2'b01: begin
          if (off[1]) mem[widx][15:0]  <= data_in[15:0];
          else        mem[widx][31:16] <= data_in[15:0];
        end
        default: mem[widx] <= data_in;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_RESET;
      clr_idx         <= '0;
      rdata_valid_out <= 1'b0;
      data_out        <= 32'h0;
      fault_out       <= 1'b0;
    end else begin
      case (state)
        // The RESET cycle also clears word 0, so the sweep costs exactly WORDS cycles.
        S_RESET: begin
          if (CLEAR_ON_RESET) begin
            clr_idx <= clr_idx + 1'b1;
            state   <= S_CLEAR;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == {IW{1'b1}}) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      rdata_valid_out <= accept & ~write_in;
      fault_out       <= accept & req_fault;
      if (accept & ~write_in) data_out <= req_fault ? 32'h0 : rext;
    end
  end

endmodule

// File: tb/tb_byte_data_memory.sv
// tb/tb_byte_data_memory.sv - scoreboard bench for byte_data_memory
// Expected responses are queued at drive time and popped the cycle after acceptance.
module tb_byte_data_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic        write_in = 1'b0;
  logic [1:0]  size_in = 2'b10;
  logic        unsigned_in = 1'b0;
  logic [31:0] address_in = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic        rdata_valid_out;
  logic [31:0] data_out;
  logic        fault_out;

  typedef struct packed {
    logic        w;
    logic        f;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic acc_q = 1'b0;
  logic mon_en = 1'b0;

  byte_data_memory #(.ADDR_W(10), .CLEAR_ON_RESET(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .write_in        (write_in),
    .size_in         (size_in),
    .unsigned_in     (unsigned_in),
    .address_in      (address_in),
    .data_in         (data_in),
    .rdata_valid_out (rdata_valid_out),
    .data_out        (data_out),
    .fault_out       (fault_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) acc_q <= rst_n && req_valid_in && (req_ready_out === 1'b1);

  always @(negedge clk) begin
    if (mon_en) begin
      if (acc_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rvalid", {31'h0, rdata_valid_out}, {31'h0, ~e.w});
          check("fault", {31'h0, fault_out}, {31'h0, e.f});
          if (!e.w) check("rdata", data_out, e.d);
        end
      end else begin
        check("idle_pulse", {30'h0, rdata_valid_out, fault_out}, 32'h0);
      end
    end
  end

  // Called right after a negedge; the request is accepted at the following posedge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_f);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 2000 && req_ready_out !== 1'b1; i++) @(negedge clk);
    if (req_ready_out !== 1'b1) check("ready_timeout", {31'h0, req_ready_out}, 32'd1);
    req_valid_in = 1'b1;
    write_in     = w;
    size_in      = sz;
    unsigned_in  = uns;
    address_in   = addr;
    data_in      = wd;
    e.w = w; e.f = exp_f; e.d = exp_d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid_in = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  // Pulls reset for one edge (optionally with a load presented) and times the clear sweep.
  task automatic do_reset(input bit inflight);
    int cnt;
    @(negedge clk);
    rst_n = 1'b0;
    if (inflight) begin
      req_valid_in = 1'b1; write_in = 1'b0; size_in = 2'b10; address_in = 32'h40;
    end
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready_out}, 32'd0);
    check("rst_rvalid", {31'h0, rdata_valid_out}, 32'd0);
    check("rst_fault", {31'h0, fault_out}, 32'd0);
    check("rst_data", data_out, 32'h0);
    req_valid_in = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    cnt = 0;
    while (req_ready_out !== 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("clear_cycles", cnt, 32'd256);
  endtask

  initial begin
    do_reset(1'b0);

    for (int a = 0; a <= 1020; a += 4) issue(0, 2'b10, 0, a, 0, 32'h0, 0);
    idle(2);

    issue(1, 2'b10, 0, 32'h10, 32'h80F1A27C, 32'h0, 0);
    issue(0, 2'b00, 0, 32'h10, 0, 32'hFFFFFF80, 0);
    issue(0, 2'b00, 1, 32'h10, 0, 32'h00000080, 0);
    issue(0, 2'b01, 0, 32'h10, 0, 32'hFFFF80F1, 0);
    issue(0, 2'b01, 1, 32'h10, 0, 32'h000080F1, 0);
    issue(0, 2'b10, 0, 32'h10, 0, 32'h80F1A27C, 0);

    issue(1, 2'b00, 0, 32'h13, 32'h00000055, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h10, 0, 32'h80F1A255, 0);
    issue(1, 2'b01, 0, 32'h12, 32'h00001234, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h10, 0, 32'h80F11234, 0);
    issue(0, 2'b00, 1, 32'h11, 0, 32'h000000F1, 0);
    issue(0, 2'b00, 0, 32'h12, 0, 32'h00000012, 0);
    idle(2);

    issue(0, 2'b10, 0, 32'h0E, 0, 32'h0, 1);
    issue(0, 2'b01, 0, 32'h21, 0, 32'h0, 1);
    issue(0, 2'b11, 0, 32'h00, 0, 32'h0, 1);
    issue(1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0, 1);
    issue(1, 2'b01, 0, 32'h0D, 32'hFFFFFFFF, 32'h0, 1);
    issue(0, 2'b10, 0, 32'h0C, 0, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h00, 0, 32'h0, 0);
    idle(2);

    issue(1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h40, 0, 32'hDEADBEEF, 0);
    issue(0, 2'b01, 1, 32'h42, 0, 32'h0000BEEF, 0);
    issue(0, 2'b00, 0, 32'h43, 0, 32'hFFFFFFEF, 0);
    idle(3);
    check("hold_data", data_out, 32'hFFFFFFEF);

    issue(0, 2'b10, 0, 32'h40, 0, 32'hDEADBEEF, 0);
    idle(1);
    do_reset(1'b0);
    for (int i = 0; i < 100; i++) @(negedge clk);
    do_reset(1'b0);
    issue(0, 2'b10, 0, 32'h40, 0, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h40, 0, 32'h12345678, 0);
    idle(2);
    do_reset(1'b1);
    issue(0, 2'b10, 0, 32'h40, 0, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h10, 0, 32'h0, 0);
    idle(3);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
